// File: rtl/fetch_unit_mo_pkg.sv
// rtl/fetch_unit_mo_pkg.sv - shared widths, bus field offsets and packing helper for the fetch stage
// Purpose: holds the bus width macros used in port declarations plus the
//          field offsets of the fetch-to-decode bus and a packing function.
// Ports:   none (package).
`ifndef WIDTH_BR_BUS
`define WIDTH_BR_BUS 34
`endif
`ifndef WIDTH_FS_TO_DS_BUS
`define WIDTH_FS_TO_DS_BUS 65
`endif

package fetch_unit_mo_pkg;

    localparam int PC_LSB       = 0;
    localparam int INST_LSB     = 32;
    localparam int ADEF_BIT     = 64;
    localparam int BR_TAKEN_BIT = 32;
    localparam int BR_STALL_BIT = 33;

    localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

    function automatic logic [`WIDTH_FS_TO_DS_BUS-1:0] pack_fs_bus(
        input logic        adef,
        input logic [31:0] inst,
        input logic [31:0] pc
    );
        logic [`WIDTH_FS_TO_DS_BUS-1:0] bus;
        bus                        = '0;
        bus[ADEF_BIT]              = adef;
        bus[INST_LSB +: 32]        = inst;
        bus[PC_LSB +: 32]          = pc;
        return bus;
    endfunction

endpackage

// File: rtl/fetch_unit_mo_if.sv
// rtl/fetch_unit_mo_if.sv - instruction SRAM-like request/response bus
// Purpose: groups the inst_sram request and response signals.
// Modports: master (fetch stage drives req/addr, receives addr_ok/data_ok/rdata),
//           slave (memory side).
interface fetch_unit_mo_if;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

endinterface

// File: rtl/fetch_unit_mo_fetch_fifo.sv
// rtl/fetch_unit_mo_fetch_fifo.sv - parametrised synchronous FIFO with clear
// Purpose: WIDTH x DEPTH FIFO; clear has priority over push/pop. Push while
//          full is accepted when a pop happens in the same cycle.
// Ports:   clk, reset (sync, active-high), clear, push/push_data,
//          pop/pop_data (head, valid when !empty), count, full, empty.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit_mo.sv
// rtl/fetch_unit_mo.sv - multi-outstanding instruction fetch stage with instruction buffer
// Purpose: keeps up to MAX_OUTSTANDING fetches in flight, buffers returned
//          instructions in an IBUF_DEPTH-entry queue for ID, and discards
//          stale responses after a flush or branch redirect.
// Ports:   clk, reset (sync, active-high); flush/flush_pc from WB;
//          br_bus {br_stall, br_taken, br_target} from ID; ds_allow_in,
//          fs_to_ds_valid, fs_to_ds_bus {adef, inst, pc} to ID;
//          inst_sram (fetch_unit_mo_if.master) instruction bus.
// Option:  IBUF_BYPASS_EN - a response arriving with an empty buffer is
//          presented to ID in the same cycle as data_ok.
module fetch_unit_mo
    import fetch_unit_mo_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h1C000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [31:0]                    flush_pc,
    input  logic [`WIDTH_BR_BUS-1:0]       br_bus,
    input  logic                           ds_allow_in,
    output logic                           fs_to_ds_valid,
    output logic [`WIDTH_FS_TO_DS_BUS-1:0] fs_to_ds_bus,
    fetch_unit_mo_if.master                inst_sram
);

    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int ICW = $clog2(IBUF_DEPTH + 1);
    localparam int DCW = 8;

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic        kill;
    logic [31:0] kill_pc;

    logic [31:0]    fetch_pc;
    logic           halted;
    logic [DCW-1:0] discard_cnt;

    logic [OCW-1:0] out_cnt;
    logic [31:0]    pc_head;
    logic           pc_full;
    logic           pc_empty;

    logic [`WIDTH_FS_TO_DS_BUS-1:0] ibuf_head;
    logic [`WIDTH_FS_TO_DS_BUS-1:0] ibuf_wdata;
    logic [`WIDTH_FS_TO_DS_BUS-1:0] resp_entry;
    logic [ICW-1:0] ibuf_count;
    logic           ibuf_full;
    logic           ibuf_empty;
    logic           ibuf_push;
    logic           ibuf_pop;

    logic misaligned;
    logic has_slot;
    logic req;
    logic accept;
    logic data_ok;
    logic resp_drop;
    logic resp_live;
    logic adef_push;

    assign br_stall  = br_bus[BR_STALL_BIT];
    assign br_taken  = br_bus[BR_TAKEN_BIT];
    assign br_target = br_bus[31:0];
    assign redirect  = br_taken && !flush;
    assign kill      = flush || redirect;
    assign kill_pc   = flush ? flush_pc : br_target;

    assign data_ok   = inst_sram.inst_sram_data_ok;
    assign misaligned = (fetch_pc[1:0] != 2'b00);

    // Reserving a buffer slot for every live outstanding request means
    // data_ok never needs backpressure. The pc FIFO count is out_cnt.
    assign has_slot  = (int'(out_cnt) + int'(ibuf_count)) < IBUF_DEPTH;
    assign req       = !reset && !kill && !br_stall && !halted && !misaligned
                       && !pc_full && has_slot;
    assign accept    = req && inst_sram.inst_sram_addr_ok;

    // Stale responses are the oldest in flight, so they are consumed first
    // and never touch the pc FIFO (it was cleared when they were killed).
    assign resp_drop = data_ok && (discard_cnt != '0);
    assign resp_live = data_ok && (discard_cnt == '0);

    // A misaligned pc is reported once in order, after older fetches drained.
    assign adef_push = !reset && !kill && !halted && misaligned && pc_empty && !ibuf_full;

    assign resp_entry = pack_fs_bus(1'b0, inst_sram.inst_sram_rdata, pc_head);
    assign ibuf_wdata = adef_push ? pack_fs_bus(1'b1, 32'h0, fetch_pc) : resp_entry;
    assign ibuf_pop   = !ibuf_empty && ds_allow_in;

`ifdef IBUF_BYPASS_EN
    logic bypass;
    assign bypass         = ibuf_empty && resp_live;
    assign fs_to_ds_valid = !reset && (!ibuf_empty || bypass);
    assign fs_to_ds_bus   = ibuf_empty ? resp_entry : ibuf_head;
    assign ibuf_push      = adef_push || (resp_live && !(bypass && ds_allow_in));
`else
    assign fs_to_ds_valid = !reset && !ibuf_empty;
    assign fs_to_ds_bus   = ibuf_head;
    assign ibuf_push      = adef_push || resp_live;
`endif

    assign inst_sram.inst_sram_req   = req;
    assign inst_sram.inst_sram_wr    = 1'b0;
    assign inst_sram.inst_sram_size  = SRAM_SIZE_WORD;
    assign inst_sram.inst_sram_wstrb = 4'h0;
    assign inst_sram.inst_sram_addr  = fetch_pc;
    assign inst_sram.inst_sram_wdata = 32'h0;

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (kill),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .pop_data  (pc_head),
        .count     (out_cnt),
        .full      (pc_full),
        .empty     (pc_empty)
    );

    fetch_fifo #(
        .WIDTH (`WIDTH_FS_TO_DS_BUS),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .clear     (kill),
        .push      (ibuf_push),
        .push_data (ibuf_wdata),
        .pop       (ibuf_pop),
        .pop_data  (ibuf_head),
        .count     (ibuf_count),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            halted      <= 1'b0;
            discard_cnt <= '0;
        end else if (kill) begin
            // Everything still in flight, minus whatever returns this cycle,
            // becomes stale.
            fetch_pc    <= kill_pc;
            halted      <= 1'b0;
            discard_cnt <= discard_cnt + DCW'(out_cnt) - DCW'(data_ok);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (adef_push) begin
                halted <= 1'b1;
            end
            if (resp_drop) begin
                discard_cnt <= discard_cnt - DCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && data_ok) begin
            assert (!pc_empty || discard_cnt != '0);
        end
    end

endmodule
